// File: rtl/data_mem_bhw.sv
// data_mem_bhw: MEM-stage data memory, byte-addressed and little-endian.
// Supports byte/half/word loads with sign or zero extension and byte-enable stores.
// Misaligned accesses are suppressed and flagged for one cycle.
// After every reset the array clears itself one word per clock while o_busy is high.
// A registered debug port returns the raw word at i_dbg_addr on every edge.
//
// Handshake: there is no valid/ready pair. A request is i_mem_read or i_mem_write
// sampled high on a rising edge. It takes effect only when o_busy is low on that edge.
// A load result appears on o_data one edge later and holds until the next accepted load.
module data_mem_bhw #(
    parameter int B = 32,
    parameter int W = 5,
    localparam int L   = B / 8,
    localparam int OFF = $clog2(L)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_mem_read,
    input  logic             i_mem_write,
    input  logic [1:0]       i_size,
    input  logic             i_unsigned,
    input  logic [W+OFF-1:0] i_addr,
    input  logic [B-1:0]     i_data,
    input  logic [W-1:0]     i_dbg_addr,
    output logic [B-1:0]     o_data,
    output logic [B-1:0]     o_dbg_data,
    output logic             o_misaligned,
    output logic             o_busy
);

    typedef enum logic {ST_CLEAR = 1'b0, ST_IDLE = 1'b1} state_t;

    localparam logic [B-1:0] BYTE_MASK = B'(8'hFF);
    localparam logic [B-1:0] HALF_MASK = B'(16'hFFFF);

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   clr_cnt_q;
    logic           busy;

    logic [B-1:0]   mem [2**W];

    logic           is_byte;
    logic           is_half;
    logic           is_word;
    logic [OFF-1:0] addr_off;
    logic [W-1:0]   widx;
    logic           misaligned;
    logic           access;
    logic           do_write;
    logic           do_read;
    logic [L-1:0]   byte_en;
    logic [OFF-1:0] lane;
    logic [B-1:0]   wdata;
    logic [B-1:0]   rd_word;
    logic [B-1:0]   shifted;
    logic           ext_bit;
    logic [B-1:0]   load_val;

    // State register: reset always restarts the clear sweep.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_CLEAR;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: leave CLEAR on the edge that clears the last word; IDLE is terminal.
    always_comb begin
        state_d = state_q;
        if (state_q == ST_CLEAR && clr_cnt_q == {W{1'b1}}) begin
            state_d = ST_IDLE;
        end
    end

    // FSM outputs: busy for the whole clear sweep.
    always_comb begin
        busy   = (state_q == ST_CLEAR);
        o_busy = busy;
    end

    // Clear counter: walks word 0 upward while clearing.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            clr_cnt_q <= '0;
        end else if (busy) begin
            clr_cnt_q <= clr_cnt_q + 1'b1;
        end
    end

    // Request decode: alignment, accept conditions, lane enables and replicated store data.
    always_comb begin
        is_byte    = (i_size == 2'b00);
        is_half    = (i_size == 2'b01);
        is_word    = i_size[1];
        addr_off   = i_addr[OFF-1:0];
        widx       = i_addr[W+OFF-1:OFF];
        misaligned = (is_half & addr_off[0]) | (is_word & (addr_off != '0));
        access     = ~busy & (i_mem_read | i_mem_write);
        // A write wins over a simultaneous read; the read is dropped.
        do_write   = ~busy & i_mem_write & ~misaligned;
        do_read    = ~busy & i_mem_read & ~i_mem_write & ~misaligned;
        byte_en    = '0;
        lane       = '0;
        for (int i = 0; i < L; i++) begin
            lane       = i[OFF-1:0];
            byte_en[i] = is_word
                       | (is_half & ((lane >> 1) == (addr_off >> 1)))
                       | (is_byte & (lane == addr_off));
        end
        if (is_word) begin
            wdata = i_data;
        end else if (is_half) begin
            wdata = {(L/2){i_data[15:0]}};
        end else begin
            wdata = {L{i_data[7:0]}};
        end
    end

    // Load path: aligned offsets let one byte shift serve both byte and half selects.
    always_comb begin
        rd_word = mem[widx];
        shifted = rd_word >> {addr_off, 3'b000};
        ext_bit = 1'b0;
        if (is_word) begin
            load_val = rd_word;
        end else if (is_half) begin
            ext_bit  = ~i_unsigned & shifted[15];
            load_val = ({B{ext_bit}} & ~HALF_MASK) | (shifted & HALF_MASK);
        end else begin
            ext_bit  = ~i_unsigned & shifted[7];
            load_val = ({B{ext_bit}} & ~BYTE_MASK) | (shifted & BYTE_MASK);
        end
    end

    // Array write: clear sweep while busy, otherwise byte-enabled stores.
    always_ff @(posedge i_clk) begin
        if (busy) begin
            mem[clr_cnt_q] <= '0;
        end else if (do_write) begin
            for (int i = 0; i < L; i++) begin
                if (byte_en[i]) begin
                    mem[widx][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Registered outputs: load result, read-first debug word, one-cycle misalign flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_data       <= '0;
            o_dbg_data   <= '0;
            o_misaligned <= 1'b0;
        end else begin
            o_dbg_data   <= mem[i_dbg_addr];
            o_misaligned <= access & misaligned;
            if (do_read) begin
                o_data <= load_val;
            end
        end
    end

endmodule
